// File: rtl/mve_pkg.sv
// Shared types and default widths for the matrix-vector engine.
package mve_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_NUM_CH = 8;

endpackage

// File: rtl/mac_unit.sv
// One multiply-accumulate lane: registered product, then accumulate.
// Latency: product 1 cycle after en, accumulator updated 1 cycle after that.
// Backpressure: none; en is a single-cycle valid with no stall path.
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);
    // One spare bit keeps the unsigned 255*255 case positive in a signed product.
    localparam int PROD_W = 2*DATA_W + 1;
    localparam int SUM_W  = (ACC_W > PROD_W) ? ACC_W : PROD_W;

    logic signed [PROD_W-1:0] a_w;
    logic signed [PROD_W-1:0] b_w;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  prod_wide;
    logic                     prod_vld;

    always_comb begin
        a_w       = (SIGNED != 0) ? PROD_W'($signed(a)) : PROD_W'(a);
        b_w       = (SIGNED != 0) ? PROD_W'($signed(b)) : PROD_W'(b);
        prod_wide = SUM_W'(prod);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else if (clr) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else begin
            prod     <= a_w * b_w;
            prod_vld <= en;
            if (prod_vld) begin
                acc <= acc + prod_wide[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mat_vec_engine.sv
// NUM_CH x DEPTH matrix-vector multiply: fill row/vector FIFOs, then parallel MAC lanes.
// Latency: EXEC lasts DEPTH+2 cycles after the last FIFO fills; result registered into DONE.
// Backpressure: wr_ready low when not in FILL or target FIFO full; dropped writes set err.
module mat_vec_engine import mve_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SIGNED = 0,
    parameter int ACC_W  = 2*DATA_W + $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_CH+1)-1:0] wr_sel,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       start,
    output logic                       wr_ready,
    output logic [1:0]                 state,
    output logic                       done,
    output logic                       err,
    output logic [NUM_CH*ACC_W-1:0]    result
);
    localparam int SEL_W = $clog2(NUM_CH+1);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int EXC_W = $clog2(DEPTH+2);

    state_t             state_q;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt [NUM_CH+1];
    logic [DATA_W-1:0]  mem [NUM_CH+1][DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [EXC_W-1:0]   exec_cnt;
    logic [ACC_W-1:0]   acc [NUM_CH];

    logic [CNT_W-1:0]   sel_cnt;
    logic               sel_ok;
    logic               accept;
    logic               all_full;
    logic               pop;
    logic               exec_last;
    logic               restart;

    always_comb begin
        sel_cnt = '0;
        for (int j = 0; j <= NUM_CH; j++) begin
            if (wr_sel == SEL_W'(j)) begin
                sel_cnt = cnt[j];
            end
        end
        all_full = 1'b1;
        for (int j = 0; j <= NUM_CH; j++) begin
            if (cnt[j] != CNT_W'(DEPTH)) begin
                all_full = 1'b0;
            end
        end
        sel_ok    = (wr_sel <= SEL_W'(NUM_CH)) && (sel_cnt < CNT_W'(DEPTH));
        wr_ready  = (state_q == FILL) && sel_ok;
        accept    = wr_en && wr_ready;
        pop       = (state_q == EXEC) && (exec_cnt < EXC_W'(DEPTH));
        exec_last = (state_q == EXEC) && (exec_cnt == EXC_W'(DEPTH+1));
        restart   = (state_q == DONE) && start;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            FILL:    if (all_full)  state_n = EXEC;
            EXEC:    if (exec_last) state_n = DONE;
            DONE:    if (start)     state_n = FILL;
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            rd_ptr   <= '0;
            exec_cnt <= '0;
            err      <= 1'b0;
            result   <= '0;
            for (int j = 0; j <= NUM_CH; j++) begin
                cnt[j] <= '0;
            end
        end else begin
            state_q  <= state_n;
            exec_cnt <= (state_q == EXEC) ? exec_cnt + 1'b1 : '0;
            if (restart) begin
                rd_ptr <= '0;
                err    <= 1'b0;
                result <= '0;
                for (int j = 0; j <= NUM_CH; j++) begin
                    cnt[j] <= '0;
                end
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (wr_en && !accept) begin
                    err <= 1'b1;
                end
                for (int j = 0; j <= NUM_CH; j++) begin
                    if (accept && (wr_sel == SEL_W'(j))) begin
                        cnt[j] <= cnt[j] + 1'b1;
                    end
                end
                if (exec_last) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        result[i*ACC_W +: ACC_W] <= acc[i];
                    end
                end
            end
        end
    end

    // Data storage carries no reset; the write pointer is the FIFO's count.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j <= NUM_CH; j++) begin
                if (wr_sel == SEL_W'(j)) begin
                    mem[j][cnt[j][PTR_W-1:0]] <= wr_data;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
            mac_unit #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_mac (
                .clk (clk),
                .rst (rst),
                .clr (restart),
                .en  (pop),
                .a   (mem[i][rd_ptr]),
                .b   (mem[NUM_CH][rd_ptr]),
                .acc (acc[i])
            );
        end
    endgenerate

    assign state = state_q;
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_mat_vec_engine.sv
// Bench for mat_vec_engine: unsigned and signed instances driven in lockstep,
// table vectors plus random loads, restart and mid-EXEC reset sequences.
module tb_mat_vec_engine;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int NUM_CH = 8;
    localparam int ACC_W  = 2*DATA_W + $clog2(DEPTH);
    localparam int SEL_W  = $clog2(NUM_CH+1);
    localparam int RW     = NUM_CH*ACC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [SEL_W-1:0]  wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic              start;

    logic              wr_ready_u, done_u, err_u;
    logic [1:0]        state_u;
    logic [RW-1:0]     result_u;
    logic              wr_ready_s, done_s, err_s;
    logic [1:0]        state_s;
    logic [RW-1:0]     result_s;

    always #5 clk = ~clk;

    mat_vec_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .start(start), .wr_ready(wr_ready_u), .state(state_u), .done(done_u),
        .err(err_u), .result(result_u)
    );

    mat_vec_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .SIGNED(1)) u_sdut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .start(start), .wr_ready(wr_ready_s), .state(state_s), .done(done_s),
        .err(err_s), .result(result_s)
    );

    typedef struct {
        logic [7:0] a0;
        logic [7:0] da;
        logic [7:0] b0;
        logic [7:0] db;
        bit         extra;
        int         eu;
        int         es;
    } vec_t;

    typedef struct {
        logic [RW-1:0] u;
        logic [RW-1:0] s;
        logic          err;
    } exp_t;

    vec_t              tbl [7];
    exp_t              sb [$];
    logic [DATA_W-1:0] a_mat [NUM_CH][DEPTH];
    logic [DATA_W-1:0] b_vec [DEPTH];
    int                n_vec = 0;
    int                n_miss = 0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    function automatic logic [RW-1:0] rep(input int v);
        logic [RW-1:0] r;
        logic [31:0]   t;
        t = v;
        for (int i = 0; i < NUM_CH; i++) r[i*ACC_W +: ACC_W] = t[ACC_W-1:0];
        return r;
    endfunction

    function automatic logic [RW-1:0] model(input bit sgn);
        logic [RW-1:0] r;
        int s, x, y;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s = 0;
            for (int k = 0; k < DEPTH; k++) begin
                x = sgn ? int'($signed(a_mat[i][k])) : int'(a_mat[i][k]);
                y = sgn ? int'($signed(b_vec[k])) : int'(b_vec[k]);
                s += x * y;
            end
            r[i*ACC_W +: ACC_W] = s[ACC_W-1:0];
        end
        return r;
    endfunction

    task automatic set_pattern(input vec_t v);
        logic [7:0] kk;
        for (int k = 0; k < DEPTH; k++) begin
            kk = 8'(k);
            b_vec[k] = v.b0 + kk * v.db;
            for (int i = 0; i < NUM_CH; i++) a_mat[i][k] = v.a0 + kk * v.da;
        end
    endtask

    task automatic do_write(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // B is loaded first so an overflow write can be tried before everything is full.
    task automatic load(input bit extra);
        for (int k = 0; k < DEPTH; k++) do_write(SEL_W'(NUM_CH), b_vec[k]);
        if (extra) begin
            wr_sel = SEL_W'(NUM_CH); #1;
            chk("wr_ready_b_full", wr_ready_u, 0);
            do_write(SEL_W'(NUM_CH), 8'h77);
            chk("err_after_drop", err_u, 1);
        end
        for (int i = 0; i < NUM_CH; i++)
            for (int k = 0; k < DEPTH; k++) do_write(SEL_W'(i), a_mat[i][k]);
        wr_sel = '0;
    endtask

    task automatic run_and_check();
        int   n;
        int   len;
        exp_t e;
        n = 0;
        while (state_u == 2'd0 && n < 20) begin @(negedge clk); n++; end
        chk("enter_exec", state_u, 1);
        len = 0;
        while (state_u == 2'd1 && len < 50) begin @(negedge clk); len++; end
        chk("exec_len", len, DEPTH + 2);
        chk("state_done", state_u, 2);
        chk("done", done_u, 1);
        if (sb.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL scoreboard_empty: got no entry, expected one");
        end else begin
            e = sb.pop_front();
            chk("result_unsigned", result_u, e.u);
            chk("result_signed", result_s, e.s);
            chk("err_sticky", err_u, {{(RW-1){1'b0}}, e.err});
            chk("err_signed", err_s, {{(RW-1){1'b0}}, e.err});
        end
    endtask

    task automatic restart();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("restart_state", state_u, 0);
        chk("restart_result", result_u, 0);
        chk("restart_result_s", result_s, 0);
        chk("restart_err", err_u, 0);
        chk("restart_wr_ready", wr_ready_u, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; wr_sel = '0; wr_data = '0;
        tbl[0] = '{8'd0,   8'd5, 8'd0,   8'd10, 1'b0, 7000,   7000};
        tbl[1] = '{8'hFF,  8'd0, 8'd127, 8'd0,  1'b0, 259080, -1016};
        tbl[2] = '{8'd0,   8'd5, 8'd0,   8'd10, 1'b1, 7000,   7000};
        tbl[3] = '{8'd1,   8'd0, 8'd2,   8'd0,  1'b0, 16,     16};
        tbl[4] = '{8'hFF,  8'd0, 8'hFF,  8'd0,  1'b0, 520200, 8};
        tbl[5] = '{8'h80,  8'd0, 8'h80,  8'd0,  1'b0, 131072, 131072};
        tbl[6] = '{8'h80,  8'd0, 8'h7F,  8'd0,  1'b0, 130048, -130048};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", state_u, 0);
        chk("reset_done", done_u, 0);
        chk("reset_err", err_u, 0);
        chk("reset_result", result_u, 0);
        chk("reset_wr_ready", wr_ready_u, 1);
        @(posedge clk); #1 rst = 1'b0;

        for (int t = 0; t < 7; t++) begin
            set_pattern(tbl[t]);
            sb.push_back('{rep(tbl[t].eu), rep(tbl[t].es), tbl[t].extra});
            load(tbl[t].extra);
            run_and_check();
            restart();
        end

        // Random per-row data; start held through the first load must be ignored.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                b_vec[k] = 8'($urandom);
                for (int i = 0; i < NUM_CH; i++) a_mat[i][k] = 8'($urandom);
            end
            sb.push_back('{model(1'b0), model(1'b1), 1'b0});
            start = (r == 0);
            load(1'b0);
            start = 1'b0;
            run_and_check();
            restart();
        end

        // Reset in EXEC cycle 4 after a dropped write.
        set_pattern(tbl[0]);
        load(1'b1);
        n = 0;
        while (state_u != 2'd1 && n < 20) begin @(negedge clk); n++; end
        chk("rst_seq_exec", state_u, 1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midexec_rst_state", state_u, 0);
        chk("midexec_rst_result", result_u, 0);
        chk("midexec_rst_err", err_u, 0);
        chk("midexec_rst_wr_ready", wr_ready_u, 1);
        chk("midexec_rst_done", done_u, 0);
        @(posedge clk); #1 rst = 1'b0;

        set_pattern(tbl[3]);
        sb.push_back('{rep(16), rep(16), 1'b0});
        load(1'b0);
        run_and_check();
        restart();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
